// File: rtl/aibnd_rx_word_deser.sv
// Serial-to-parallel word receiver for the aibnd RX data path: hunts for an
// alignment marker, confirms it, then deserializes MSB-first words into a small FIFO.
module aibnd_rx_word_deser #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] MARKER   = 8'hA5,
    parameter int               LOCK_CNT = 2,
    parameter int               DEPTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sig_in,
    input  logic                     en,
    input  logic                     relock,
    output logic [WIDTH-1:0]         dout_data,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic                     locked,
    output logic                     ovf,
    output logic [$clog2(DEPTH):0]   fifo_cnt
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int MW = $clog2(LOCK_CNT + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sr_q, sr_next;
    logic [BW-1:0]    bitcnt_q, bitcnt_d;
    logic [MW-1:0]    matchcnt_q, matchcnt_d;
    logic             boundary, push, pop, full, push_ok;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] last_head_q;
    logic             ovf_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= HUNT;
            sr_q       <= '0;
            bitcnt_q   <= '0;
            matchcnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sr_q       <= sr_next;
            bitcnt_q   <= bitcnt_d;
            matchcnt_q <= matchcnt_d;
        end
    end

    assign sr_next  = en ? {sr_q[WIDTH-2:0], sig_in} : sr_q;
    assign boundary = (bitcnt_q == BW'(WIDTH - 1));

    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        matchcnt_d = matchcnt_q;
        push       = 1'b0;
        if (relock) begin
            state_d    = HUNT;
            bitcnt_d   = '0;
            matchcnt_d = '0;
        end else if (en) begin
            unique case (state_q)
                HUNT: begin
                    bitcnt_d = '0;
                    if (sr_next == MARKER) begin
                        state_d    = CONFIRM;
                        matchcnt_d = '0;
                    end
                end
                CONFIRM: begin
                    bitcnt_d = boundary ? '0 : bitcnt_q + BW'(1);
                    if (boundary) begin
                        if (sr_next != MARKER) begin
                            state_d    = HUNT;
                            matchcnt_d = '0;
                        end else if (matchcnt_q == MW'(LOCK_CNT - 1)) begin
                            state_d    = LOCKED;
                            matchcnt_d = '0;
                        end else begin
                            matchcnt_d = matchcnt_q + MW'(1);
                        end
                    end
                end
                LOCKED: begin
                    bitcnt_d = boundary ? '0 : bitcnt_q + BW'(1);
                    push     = boundary;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign full    = (cnt_q == CW'(DEPTH));
    assign pop     = (cnt_q != '0) && dout_ready && !relock;
    assign push_ok = push && (!full || pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            last_head_q <= '0;
            ovf_q       <= 1'b0;
        end else if (relock) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr_q <= wr_ptr_q + AW'(1);
            if (push && !push_ok)
                ovf_q <= 1'b1;
            if (pop) begin
                rd_ptr_q    <= rd_ptr_q + AW'(1);
                last_head_q <= mem[rd_ptr_q];
            end
            cnt_q <= cnt_q + CW'(push_ok) - CW'(pop);
        end
    end

    // NOTE: storage is left unreset; the head is only read when cnt_q says it holds data.
    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr_q] <= sr_next;
    end

    assign dout_valid = (cnt_q != '0);
    assign dout_data  = dout_valid ? mem[rd_ptr_q] : last_head_q;
    assign locked     = (state_q == LOCKED);
    assign ovf        = ovf_q;
    assign fifo_cnt   = cnt_q;

endmodule

// File: tb/tb_aibnd_rx_word_deser.sv
// Directed bench for aibnd_rx_word_deser: bit-level stimulus with a queue of
// expected FIFO words checked as the consumer pops them.
module tb_aibnd_rx_word_deser;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst, sig_in, en, relock, dout_ready;
    logic [WIDTH-1:0] dout_data;
    logic             dout_valid, locked, ovf;
    logic [$clog2(DEPTH):0] fifo_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [WIDTH-1:0] exp_q[$];

    aibnd_rx_word_deser #(
        .WIDTH(WIDTH), .MARKER(8'hA5), .LOCK_CNT(2), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .sig_in(sig_in), .en(en), .relock(relock),
        .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .locked(locked), .ovf(ovf), .fifo_cnt(fifo_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        en     = 1'b1;
        sig_in = b;
        @(posedge clk); #1;
    endtask

    task automatic send_word(input logic [WIDTH-1:0] w, input bit expect_push);
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i]);
        if (expect_push) exp_q.push_back(w);
    endtask

    task automatic do_lock();
        send_word(8'h00, 1'b0);
        repeat (3) send_word(8'hA5, 1'b0);
    endtask

    task automatic pulse_relock();
        relock = 1'b1;
        @(posedge clk); #1;
        relock = 1'b0;
    endtask

    // Pop n words with the shifter frozen, comparing each head to the scoreboard.
    task automatic drain(input int n);
        logic [WIDTH-1:0] w;
        en = 1'b0;
        for (int i = 0; i < n; i++) begin
            check("drain_valid", 32'(dout_valid), 32'd1);
            if (exp_q.size() == 0) begin
                check("drain_scoreboard_empty", 32'(exp_q.size()), 32'd1);
            end else begin
                w = exp_q.pop_front();
                check("drain_data", 32'(dout_data), 32'(w));
            end
            dout_ready = 1'b1;
            @(posedge clk); #1;
            dout_ready = 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1; sig_in = 1'b0; en = 1'b0; relock = 1'b0; dout_ready = 1'b0;
        #12;
        check("rst_valid",  32'(dout_valid), 32'd0);
        check("rst_data",   32'(dout_data),  32'd0);
        check("rst_locked", 32'(locked),     32'd0);
        check("rst_ovf",    32'(ovf),        32'd0);
        check("rst_cnt",    32'(fifo_cnt),   32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Lock on three markers, then 3C and C3 flow into the FIFO.
        send_word(8'h00, 1'b0);
        send_word(8'hA5, 1'b0);
        send_word(8'hA5, 1'b0);
        for (int i = 7; i >= 1; i--) send_bit(1'(8'hA5 >> i));
        check("lock_not_yet", 32'(locked), 32'd0);
        send_bit(1'b1);
        check("lock_third_marker", 32'(locked), 32'd1);
        for (int i = 7; i >= 1; i--) send_bit(1'(8'h3C >> i));
        check("latency_before_last", 32'(dout_valid), 32'd0);
        send_bit(1'b0);
        exp_q.push_back(8'h3C);
        check("latency_valid", 32'(dout_valid), 32'd1);
        check("latency_data",  32'(dout_data),  32'h3C);
        send_word(8'hC3, 1'b1);
        check("two_words_cnt", 32'(fifo_cnt), 32'd2);
        drain(2);
        check("drained_valid", 32'(dout_valid), 32'd0);

        // Failed confirm drops back to hunt; a clean marker run locks again.
        pulse_relock();
        check("relock_unlocked", 32'(locked), 32'd0);
        send_word(8'h00, 1'b0);
        send_word(8'hA5, 1'b0);
        send_word(8'hA5, 1'b0);
        send_word(8'h5A, 1'b0);
        check("bad_confirm_locked", 32'(locked), 32'd0);
        check("bad_confirm_cnt", 32'(fifo_cnt), 32'd0);
        do_lock();
        check("relock_after_hunt", 32'(locked), 32'd1);

        // Overflow: four words fit, the fifth is dropped and ovf sticks.
        dout_ready = 1'b0;
        send_word(8'h11, 1'b1);
        send_word(8'h22, 1'b1);
        send_word(8'h33, 1'b1);
        send_word(8'h44, 1'b1);
        check("full_cnt", 32'(fifo_cnt), 32'd4);
        check("full_no_ovf", 32'(ovf), 32'd0);
        send_word(8'h55, 1'b0);
        check("ovf_cnt", 32'(fifo_cnt), 32'd4);
        check("ovf_set", 32'(ovf), 32'd1);
        drain(4);
        check("ovf_sticky", 32'(ovf), 32'd1);
        check("ovf_drained_cnt", 32'(fifo_cnt), 32'd0);

        // Full FIFO with push and pop on the same edge.
        pulse_relock();
        check("relock_clears_ovf", 32'(ovf), 32'd0);
        do_lock();
        send_word(8'h61, 1'b1);
        send_word(8'h62, 1'b1);
        send_word(8'h63, 1'b1);
        send_word(8'h64, 1'b1);
        for (int i = 7; i >= 1; i--) send_bit(1'(8'h65 >> i));
        check("pushpop_head", 32'(dout_data), 32'(exp_q.pop_front()));
        dout_ready = 1'b1;
        send_bit(1'b1);
        dout_ready = 1'b0;
        exp_q.push_back(8'h65);
        check("pushpop_cnt", 32'(fifo_cnt), 32'd4);
        check("pushpop_ovf", 32'(ovf), 32'd0);
        drain(4);

        // Asynchronous reset with three words held.
        send_word(8'h71, 1'b1);
        send_word(8'h72, 1'b1);
        send_word(8'h73, 1'b1);
        check("pre_rst_cnt", 32'(fifo_cnt), 32'd3);
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid",  32'(dout_valid), 32'd0);
        check("async_rst_data",   32'(dout_data),  32'd0);
        check("async_rst_locked", 32'(locked),     32'd0);
        check("async_rst_cnt",    32'(fifo_cnt),   32'd0);
        check("async_rst_ovf",    32'(ovf),        32'd0);
        exp_q.delete();
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        do_lock();
        check("lock_after_rst", 32'(locked), 32'd1);

        // Sample enable dropped for three cycles mid-word.
        for (int i = 7; i >= 4; i--) send_bit(1'(8'h96 >> i));
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sig_in = 1'(i);
            @(posedge clk); #1;
        end
        check("frozen_cnt", 32'(fifo_cnt), 32'd0);
        for (int i = 3; i >= 0; i--) send_bit(1'(8'h96 >> i));
        exp_q.push_back(8'h96);
        check("en_gap_cnt", 32'(fifo_cnt), 32'd1);
        drain(1);

        // Relock clears lock, contents and the sticky overflow flag.
        for (int k = 0; k < 5; k++) send_word(8'(8'h81 + k), 1'b0);
        check("pre_relock_ovf", 32'(ovf), 32'd1);
        pulse_relock();
        check("relock_locked", 32'(locked),     32'd0);
        check("relock_cnt",    32'(fifo_cnt),   32'd0);
        check("relock_ovf",    32'(ovf),        32'd0);
        check("relock_valid",  32'(dout_valid), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
